// File: rtl/ysyx_22041412_clint_bridge_pkg.sv
// Shared types and constants for the LSU-to-CLINT bridge: FSM states,
// CLINT rw_mode codes and the register offsets inside the CLINT window.
package ysyx_22041412_clint_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEC,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        RW_NONE  = 2'd0,
        RW_RTIME = 2'd1,
        RW_RCMP  = 2'd2,
        RW_WCMP  = 2'd3
    } rw_mode_e;

    localparam logic [15:0] OFS_MTIMECMP = 16'h4000;
    localparam logic [15:0] OFS_MTIME    = 16'hBFF8;

endpackage

// File: rtl/ysyx_22041412_clint_bridge_if.sv
// LSU-side request/response channel of the CLINT bridge.
interface ysyx_22041412_clint_bridge_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_22041412_clint_wmerge.sv
// Bytewise write merge: strobed bytes come from new_word, the rest from old_word.
module ysyx_22041412_clint_wmerge (
    input  logic [63:0] old_word,
    input  logic [63:0] new_word,
    input  logic [7:0]  strb,
    output logic [63:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/ysyx_22041412_clint_bridge.sv
// MMIO front end for the CLINT: decodes LSU loads/stores to mtime/mtimecmp,
// sequences single-cycle CLINT modes and returns a registered response.
module ysyx_22041412_clint_bridge
    import ysyx_22041412_clint_bridge_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE   = 32'h0200_0000,
    parameter logic [15:0] OFS_MTIMECMP = ysyx_22041412_clint_bridge_pkg::OFS_MTIMECMP,
    parameter logic [15:0] OFS_MTIME    = ysyx_22041412_clint_bridge_pkg::OFS_MTIME
) (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22041412_clint_bridge_if.slave    lsu,
    output logic                           clint_en,
    output logic [1:0]                     clint_rw_mode,
    output logic [63:0]                    clint_wdata,
    input  logic [63:0]                    clint_rdata
);

    state_e      state_q,   state_d;
    logic [31:0] addr_q,    addr_d;
    logic        wen_q,     wen_d;
    logic [63:0] wdata_q,   wdata_d;
    logic [7:0]  wstrb_q,   wstrb_d;
    logic [63:0] merge_q,   merge_d;
    rw_mode_e    rd_mode_q, rd_mode_d;
    logic        rmw_q,     rmw_d;
    logic [63:0] rdata_q,   rdata_d;
    logic        err_q,     err_d;

    rw_mode_e    mode;
    logic [63:0] merged;
    logic        hit;
    logic        at_cmp;
    logic        at_time;

    ysyx_22041412_clint_wmerge u_wmerge (
        .old_word (clint_rdata),
        .new_word (wdata_q),
        .strb     (wstrb_q),
        .merged   (merged)
    );

    assign hit     = (addr_q[31:16] == CLINT_BASE[31:16]) && (addr_q[2:0] == 3'b000);
    assign at_cmp  = hit && (addr_q[15:0] == OFS_MTIMECMP);
    assign at_time = hit && (addr_q[15:0] == OFS_MTIME);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        merge_d     = merge_q;
        rd_mode_d   = rd_mode_q;
        rmw_d       = rmw_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        clint_en    = 1'b0;
        mode        = RW_NONE;
        clint_wdata = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (lsu.req_valid) begin
                    addr_d  = lsu.req_addr;
                    wen_d   = lsu.req_wen;
                    wdata_d = lsu.req_wdata;
                    wstrb_d = lsu.req_wstrb;
                    rmw_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_DEC;
                end
            end
            ST_DEC: begin
                // A zero-strobe store is a no-op regardless of where it points.
                if (wen_q) begin
                    if (wstrb_q == 8'h00) begin
                        state_d = ST_RESP;
                    end else if (at_cmp && wstrb_q == 8'hFF) begin
                        state_d = ST_WR;
                    end else if (at_cmp) begin
                        rmw_d     = 1'b1;
                        rd_mode_d = RW_RCMP;
                        state_d   = ST_RD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end else if (at_time) begin
                    rd_mode_d = RW_RTIME;
                    state_d   = ST_RD;
                end else if (at_cmp) begin
                    rd_mode_d = RW_RCMP;
                    state_d   = ST_RD;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RD: begin
                clint_en = 1'b1;
                mode     = rd_mode_q;
                state_d  = ST_CAP;
            end
            ST_CAP: begin
                if (rmw_q) begin
                    merge_d = merged;
                    state_d = ST_WR;
                end else begin
                    rdata_d = clint_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                clint_en    = 1'b1;
                mode        = RW_WCMP;
                clint_wdata = rmw_q ? merge_q : wdata_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (lsu.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            merge_q   <= '0;
            rd_mode_q <= RW_NONE;
            rmw_q     <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            merge_q   <= merge_d;
            rd_mode_q <= rd_mode_d;
            rmw_q     <= rmw_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign clint_rw_mode = mode;
    assign lsu.req_ready = (state_q == ST_IDLE);
    assign lsu.rsp_valid = (state_q == ST_RESP);
    assign lsu.rsp_rdata = rdata_q;
    assign lsu.rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22041412_clint_bridge.sv
// Bench for the CLINT bridge: directed scenarios plus randomized requests
// against a transaction-level reference model and a simple CLINT stand-in.
module tb_ysyx_22041412_clint_bridge;

    logic        clk;
    logic        rst;
    logic        clint_en;
    logic [1:0]  clint_rw_mode;
    logic [63:0] clint_wdata;
    logic [63:0] clint_rdata;

    logic [63:0] mtime_m;
    logic [63:0] cmp_m;

    int total;
    int bad;

    ysyx_22041412_clint_bridge_if bus ();

    ysyx_22041412_clint_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .lsu           (bus.slave),
        .clint_en      (clint_en),
        .clint_rw_mode (clint_rw_mode),
        .clint_wdata   (clint_wdata),
        .clint_rdata   (clint_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CLINT stand-in: read data appears the cycle after a read mode.
    always @(posedge clk) begin
        if (clint_en && clint_rw_mode == 2'd1) clint_rdata <= mtime_m;
        else if (clint_en && clint_rw_mode == 2'd2) clint_rdata <= cmp_m;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [31:0] addr, input logic wen, input logic [63:0] wd,
                       input logic [7:0] st, input int hold);
        logic        hit;
        logic [15:0] ofs;
        int          exp_lat;
        logic [63:0] exp_rd;
        logic        exp_err;
        logic [63:0] exp_wd;
        logic [63:0] mask;
        int          exp_modes[$];
        int          obs_modes[$];
        logic [63:0] obs_wd;
        int          edges;

        exp_lat = 2; exp_rd = '0; exp_err = 1'b0; exp_wd = '0; obs_wd = '0;
        hit = (addr[31:16] == 16'h0200) && (addr[2:0] == 3'b000);
        ofs = addr[15:0];
        mask = '0;
        for (int b = 0; b < 8; b++) if (st[b]) mask = mask | (64'hFF << (8 * b));

        if (!wen) begin
            if (hit && ofs == 16'hBFF8) begin
                exp_modes.push_back(1); exp_lat = 4; exp_rd = mtime_m;
            end else if (hit && ofs == 16'h4000) begin
                exp_modes.push_back(2); exp_lat = 4; exp_rd = cmp_m;
            end else begin
                exp_err = 1'b1;
            end
        end else if (st != 8'h00) begin
            if (hit && ofs == 16'h4000) begin
                exp_wd = (wd & mask) | (cmp_m & ~mask);
                if (st == 8'hFF) begin
                    exp_lat = 3;
                end else begin
                    exp_modes.push_back(2); exp_lat = 5;
                end
                exp_modes.push_back(3);
            end else begin
                exp_err = 1'b1;
            end
        end

        bus.rsp_ready = (hold == 0);
        check64("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_wen   = wen;
        bus.req_wdata = wd;
        bus.req_wstrb = st;
        @(posedge clk);
        edges = 1;
        do begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (edges == 1) check64("req_ready_busy", 64'(bus.req_ready), 64'd0);
            if (clint_en) begin
                obs_modes.push_back(int'(clint_rw_mode));
                if (clint_rw_mode == 2'd3) obs_wd = clint_wdata;
            end
            if (!bus.rsp_valid) begin
                @(posedge clk);
                edges++;
            end
        end while (!bus.rsp_valid && edges <= 20);

        check64("latency", 64'(edges), 64'(exp_lat));
        check64("mode_count", 64'(obs_modes.size()), 64'(exp_modes.size()));
        for (int i = 0; i < exp_modes.size() && i < obs_modes.size(); i++)
            check64("mode_seq", 64'(obs_modes[i]), 64'(exp_modes[i]));
        if (exp_modes.size() != 0 && exp_modes[exp_modes.size()-1] == 3) begin
            check64("clint_wdata", obs_wd, exp_wd);
            cmp_m = exp_wd;
        end
        check64("rsp_rdata", bus.rsp_rdata, exp_rd);
        check64("rsp_err", 64'(bus.rsp_err), 64'(exp_err));

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check64("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check64("hold_rdata", bus.rsp_rdata, exp_rd);
            check64("hold_err", 64'(bus.rsp_err), 64'(exp_err));
            check64("hold_clint_idle", 64'(clint_en), 64'd0);
            check64("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check64("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        int          found;
        int          wcmp_after;
        logic [31:0] a;
        logic [7:0]  s;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        mtime_m = '0;
        cmp_m   = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wen   = 1'b0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b1;

        #1;
        check64("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check64("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check64("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        check64("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check64("rst_clint_en", 64'(clint_en), 64'd0);
        check64("rst_rw_mode", 64'(clint_rw_mode), 64'd0);
        check64("rst_clint_wdata", clint_wdata, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        mtime_m = 64'h0000_0000_0000_1234;
        txn(32'h0200_BFF8, 1'b0, 64'd0, 8'h00, 0);
        txn(32'h0200_4000, 1'b1, 64'hDEAD_BEEF_0000_0100, 8'hFF, 0);
        check64("full_write_cmp", cmp_m, 64'hDEAD_BEEF_0000_0100);
        cmp_m = 64'h1111_2222_3333_4444;
        txn(32'h0200_4000, 1'b1, 64'h0000_0000_0000_00AA, 8'h01, 0);
        check64("rmw_cmp", cmp_m, 64'h1111_2222_3333_44AA);
        txn(32'h0200_BFF8, 1'b1, 64'h55, 8'hFF, 0);
        txn(32'h0200_0010, 1'b0, 64'd0, 8'h00, 0);
        txn(32'h0200_4004, 1'b0, 64'd0, 8'h00, 0);
        txn(32'h0200_4000, 1'b1, 64'h77, 8'h00, 0);
        mtime_m = 64'hCAFE_F00D_1234_5678;
        txn(32'h0200_BFF8, 1'b0, 64'd0, 8'h00, 5);
        txn(32'h0200_4000, 1'b0, 64'd0, 8'h00, 0);

        // Randomized requests
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: a = 32'h0200_BFF8;
                1: a = 32'h0200_4000;
                2: a = 32'h0200_0010;
                3: a = 32'h0200_4000 | 32'($urandom_range(1, 7));
                4: a = 32'h0300_4000;
                default: a = 32'h0200_4000;
            endcase
            case ($urandom_range(0, 3))
                0: s = 8'h00;
                1: s = 8'hFF;
                default: s = 8'($urandom);
            endcase
            mtime_m = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 3) == 0) cmp_m = {32'($urandom), 32'($urandom)};
            txn(a, 1'($urandom), {32'($urandom), 32'($urandom)}, s, $urandom_range(0, 3));
        end

        // Reset in the middle of an RMW write
        cmp_m = 64'h0123_4567_89AB_CDEF;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0200_4000;
        bus.req_wen   = 1'b1;
        bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.req_wstrb = 8'h0F;
        @(posedge clk);
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (clint_en && clint_rw_mode == 2'd3) found = 1;
        end
        check64("reached_wr", 64'(found), 64'd1);
        rst = 1'b0;
        #1;
        check64("arst_clint_en", 64'(clint_en), 64'd0);
        check64("arst_rw_mode", 64'(clint_rw_mode), 64'd0);
        check64("arst_clint_wdata", clint_wdata, 64'd0);
        check64("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check64("arst_rsp_rdata", bus.rsp_rdata, 64'd0);
        check64("arst_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wcmp_after = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (clint_en) wcmp_after++;
        end
        check64("post_rst_no_clint", 64'(wcmp_after), 64'd0);
        check64("post_rst_ready", 64'(bus.req_ready), 64'd1);
        check64("post_rst_valid", 64'(bus.rsp_valid), 64'd0);

        mtime_m = 64'h0000_0000_0000_0042;
        txn(32'h0200_BFF8, 1'b0, 64'd0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041412_clint_bridge.md
Name: ysyx_22041412_clint_bridge

Overview:
- Memory-mapped front end directly upstream of the CLINT.
- Accepts 64-bit load/store requests from the LSU over a valid/ready handshake.
- Decodes the mtime/mtimecmp addresses and drives the CLINT's enable / rw_mode / write-data interface.
- Captures CLINT read data and returns a registered response; partial-strobe writes to mtimecmp are done as read-modify-write.

Parameters:
- CLINT_BASE, 32'h0200_0000, base address of the CLINT window.
- OFS_MTIMECMP, 16'h4000, byte offset of mtimecmp.
- OFS_MTIME, 16'hBFF8, byte offset of mtime.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  LSU request valid
- req_ready  out  1  bridge can accept; high only in IDLE
- req_addr  in  32  byte address, 8-byte aligned
- req_wen  in  1  1 = store, 0 = load
- req_wdata  in  64  store data, full 64-bit lane
- req_wstrb  in  8  byte enables for stores
- rsp_valid  out  1  response valid
- rsp_ready  in  1  LSU accepts response
- rsp_rdata  out  64  load data; 0 for stores and errors
- rsp_err  out  1  access fault
- clint_en  out  1  to CLINT mtime_en
- clint_rw_mode  out  2  to CLINT rw_mode: 0 none, 1 rtime, 2 rcmp, 3 wcmp
- clint_wdata  out  64  to CLINT data_w
- clint_rdata  in  64  from CLINT data_r; valid the cycle after a read mode is presented

Behaviour:
- Reset (rst low, async):
  - State IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
  - clint_en=0; clint_rw_mode=0; clint_wdata=0; request and merge registers cleared.
  - A reset mid-operation aborts the operation; no CLINT write is issued after reset.
- Request capture:
  - On req_valid && req_ready, register addr, wen, wdata and wstrb.
  - req_ready is 0 in every state except IDLE.
- Decode, on the registered address; hit requires addr[31:16]==CLINT_BASE[31:16] and addr[2:0]==0:
  - Load to OFS_MTIME -> read with rw_mode=1.
  - Load to OFS_MTIMECMP -> read with rw_mode=2.
  - Store to OFS_MTIMECMP, wstrb==8'hFF -> full write.
  - Store to OFS_MTIMECMP, wstrb!=0 and !=8'hFF -> read-modify-write.
  - Store with wstrb==0 -> no CLINT access; rsp_err=0.
  - Store to OFS_MTIME (CLINT has no mtime write path), any other offset, or misaligned address -> error; no CLINT access.
- States:
  - IDLE: on accept go to DEC.
  - DEC: classify; go to RD, WR, or RESP (error and wstrb==0 cases).
  - RD: clint_en=1, clint_rw_mode=1 or 2, for exactly one cycle; go to CAP.
  - CAP: sample clint_rdata.
    - Load: rsp_rdata <= clint_rdata; go to RESP.
    - RMW: merge <= per byte i, wstrb[i] ? wdata byte i : clint_rdata byte i; go to WR.
  - WR: clint_en=1, clint_rw_mode=3, clint_wdata = wdata (full) or merge (RMW), for exactly one cycle; go to RESP.
  - RESP: rsp_valid=1, holding rsp_rdata and rsp_err stable; on rsp_ready go to IDLE.
  - Outside RD and WR: clint_en=0, clint_rw_mode=0.
- Latency, in edges from the accept edge to rsp_valid high:
  - Load: 4.
  - Full write: 3.
  - RMW: 5.
  - Error / zero-strobe: 2.
- Back-to-back: the RESP -> IDLE edge gives one bubble; the next request is accepted in IDLE.
- Backpressure: rsp_ready low holds RESP indefinitely; the CLINT is idle meanwhile.
- Data rules:
  - rsp_rdata is forced to 0 on stores and errors.
  - The merge is bytewise; no sign or size handling (the LSU extracts sub-word loads).
- The bridge never issues a CLINT mode while another is in flight; exactly one mode cycle per RD or WR state.

Decomposition:
- Shared package contents:
  - State enum (IDLE, DEC, RD, CAP, WR, RESP).
  - rw_mode codes: RW_NONE=0, RW_RTIME=1, RW_RCMP=2, RW_WCMP=3.
  - Offset constants OFS_MTIME / OFS_MTIMECMP.
- One natural sub-module: ysyx_22041412_clint_wmerge, purely combinational, 64-bit old/new plus 8-bit strobe -> merged word. Reused later by other MMIO RMW paths.

Test Plan:
1. Load 0x0200_BFF8 with clint_rdata=64'h0000_0000_0000_1234 in CAP -> clint_rw_mode=1 for exactly one cycle; rsp_rdata=64'h1234, rsp_err=0, rsp_valid 4 edges after accept.
2. Store 0x0200_4000, wdata=64'hDEAD_BEEF_0000_0100, wstrb=8'hFF -> one cycle of rw_mode=3 with clint_wdata=64'hDEAD_BEEF_0000_0100, no rw_mode=2 cycle; rsp_valid 3 edges after accept; rsp_rdata=0.
3. Store 0x0200_4000, wdata=64'h0000_0000_0000_00AA, wstrb=8'h01, with clint_rdata=64'h1111_2222_3333_4444 -> rw_mode=2 cycle, then rw_mode=3 with clint_wdata=64'h1111_2222_3333_44AA; rsp_valid 5 edges after accept.
4. Store to 0x0200_BFF8, load 0x0200_0010, and load 0x0200_4004 -> rsp_err=1, rsp_rdata=0, clint_en never asserted, rsp_valid 2 edges after accept.
5. Two back-to-back loads with rsp_ready held low 5 cycles on the first -> rsp_valid/rsp_rdata stable throughout, req_ready=0 until RESP exits; second request accepted the cycle after, both data correct.
6. Assert rst low during WR of an RMW store -> all outputs at reset values immediately (async); after release no rw_mode=3 cycle occurs and req_ready=1.
